// File: rtl/pll_spi_pkg.sv
// Shared constants for the PLL configuration SPI slave.
// Holds the command codes, the protocol FSM encodings, the register address
// constants and the config reset values, plus small command-decode helpers.
package pll_spi_pkg;

  // Command byte values
  localparam logic [7:0] CMD_WRITE = 8'h80;
  localparam logic [7:0] CMD_READ  = 8'h40;
  localparam logic [7:0] CMD_RDWR  = 8'hC0;

  // Protocol FSM encodings
  localparam logic [1:0] ST_COMMAND = 2'd0;
  localparam logic [1:0] ST_ADDRESS = 2'd1;
  localparam logic [1:0] ST_DATA    = 2'd2;
  localparam logic [1:0] ST_IGNORE  = 2'd3;

  // Read-only ID registers
  localparam logic [7:0] ADDR_MFGR_HI = 8'h00;
  localparam logic [7:0] ADDR_MFGR_LO = 8'h01;
  localparam logic [7:0] ADDR_PROD    = 8'h02;
  localparam logic [7:0] ADDR_MASK    = 8'h03;

  // Channel n occupies ADDR_CH_BASE + 4n .. +3
  localparam logic [7:0] ADDR_CH_BASE = 8'h08;
  localparam logic [1:0] OFS_CFG      = 2'd0;
  localparam logic [1:0] OFS_TRIM_LO  = 2'd1;
  localparam logic [1:0] OFS_TRIM_HI  = 2'd2;

  // Config reset values
  localparam logic EN_RST     = 1'b0;
  localparam logic BYPASS_RST = 1'b1;

  function automatic logic cmd_valid(input logic [7:0] cmd);
    return (cmd == CMD_WRITE) || (cmd == CMD_READ) || (cmd == CMD_RDWR);
  endfunction

  function automatic logic cmd_reads(input logic [7:0] cmd);
    return (cmd == CMD_READ) || (cmd == CMD_RDWR);
  endfunction

  function automatic logic cmd_writes(input logic [7:0] cmd);
    return (cmd == CMD_WRITE) || (cmd == CMD_RDWR);
  endfunction

endpackage

// File: rtl/pll_spi_regbank.sv
// Register bank for the PLL configuration SPI slave.
// Decodes the write address, holds the per-channel config flops and provides
// the combinational readback mux.
//   clk, rst_n          SPI clock, asynchronous active-low reset
//   wr_en               one-cycle write strobe (full byte received)
//   wr_addr, wr_data    write target and byte
//   rd_addr, rd_data    readback address and combinational data
//   bias/cp/vco/bypass  per-channel enables and bypass
//   trim                per-channel trim, channel n at [n*TRIM_W +: TRIM_W]
module pll_spi_regbank
  import pll_spi_pkg::*;
#(
  parameter int unsigned         NUM_PLL  = 2,
  parameter int unsigned         TRIM_W   = 4,
  parameter logic [TRIM_W-1:0]   TRIM_RST = '0,
  parameter logic [11:0]         MFGR_ID  = 12'h456,
  parameter logic [7:0]          PROD_ID  = 8'h11,
  parameter logic [3:0]          MASK_REV = 4'h0
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        wr_en,
  input  logic [7:0]                  wr_addr,
  input  logic [7:0]                  wr_data,
  input  logic [7:0]                  rd_addr,
  output logic [7:0]                  rd_data,
  output logic [NUM_PLL-1:0]          bias,
  output logic [NUM_PLL-1:0]          cp,
  output logic [NUM_PLL-1:0]          vco,
  output logic [NUM_PLL-1:0]          bypass,
  output logic [NUM_PLL*TRIM_W-1:0]   trim
);

  logic [NUM_PLL-1:0]             bias_q, bias_d;
  logic [NUM_PLL-1:0]             cp_q, cp_d;
  logic [NUM_PLL-1:0]             vco_q, vco_d;
  logic [NUM_PLL-1:0]             bypass_q, bypass_d;
  logic [NUM_PLL-1:0][TRIM_W-1:0] trim_q, trim_d;

  logic [5:0]  wr_ch, rd_ch;
  logic        wr_hit, rd_hit;
  logic [15:0] wr_trim, rd_trim;

  // Write decode. Trim is widened to 16 bits so either byte can be merged;
  // bits at or above TRIM_W fall away when narrowed back.
  always_comb begin
    wr_ch    = wr_addr[7:2] - 6'd2;
    wr_hit   = wr_en && (wr_addr >= ADDR_CH_BASE) && (wr_ch < 6'(NUM_PLL));
    bias_d   = bias_q;
    cp_d     = cp_q;
    vco_d    = vco_q;
    bypass_d = bypass_q;
    trim_d   = trim_q;
    wr_trim  = '0;
    for (int unsigned n = 0; n < NUM_PLL; n++) begin
      if (wr_hit && (wr_ch == 6'(n))) begin
        wr_trim = 16'(trim_q[n]);
        case (wr_addr[1:0])
          OFS_CFG: begin
            bias_d[n]   = wr_data[0];
            cp_d[n]     = wr_data[1];
            vco_d[n]    = wr_data[2];
            bypass_d[n] = wr_data[3];
          end
          OFS_TRIM_LO: begin
            wr_trim[7:0] = wr_data;
            trim_d[n]    = wr_trim[TRIM_W-1:0];
          end
          OFS_TRIM_HI: begin
            wr_trim[15:8] = wr_data;
            trim_d[n]     = wr_trim[TRIM_W-1:0];
          end
          default: ;
        endcase
      end
    end
  end

  // Readback mux; unmapped and reserved addresses return zero.
  always_comb begin
    rd_data = '0;
    rd_trim = '0;
    rd_ch   = rd_addr[7:2] - 6'd2;
    rd_hit  = (rd_addr >= ADDR_CH_BASE) && (rd_ch < 6'(NUM_PLL));
    case (rd_addr)
      ADDR_MFGR_HI: rd_data = {4'b0, MFGR_ID[11:8]};
      ADDR_MFGR_LO: rd_data = MFGR_ID[7:0];
      ADDR_PROD:    rd_data = PROD_ID;
      ADDR_MASK:    rd_data = {4'b0, MASK_REV};
      default: ;
    endcase
    for (int unsigned n = 0; n < NUM_PLL; n++) begin
      if (rd_hit && (rd_ch == 6'(n))) begin
        rd_trim = 16'(trim_q[n]);
        case (rd_addr[1:0])
          OFS_CFG:     rd_data = {4'b0, bypass_q[n], vco_q[n], cp_q[n], bias_q[n]};
          OFS_TRIM_LO: rd_data = rd_trim[7:0];
          OFS_TRIM_HI: rd_data = rd_trim[15:8];
          default:     rd_data = '0;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bias_q   <= {NUM_PLL{EN_RST}};
      cp_q     <= {NUM_PLL{EN_RST}};
      vco_q    <= {NUM_PLL{EN_RST}};
      bypass_q <= {NUM_PLL{BYPASS_RST}};
      trim_q   <= {NUM_PLL{TRIM_RST}};
    end else begin
      bias_q   <= bias_d;
      cp_q     <= cp_d;
      vco_q    <= vco_d;
      bypass_q <= bypass_d;
      trim_q   <= trim_d;
    end
  end

  assign bias   = bias_q;
  assign cp     = cp_q;
  assign vco    = vco_q;
  assign bypass = bypass_q;
  assign trim   = trim_q;

endmodule

// File: rtl/pll_spi_ctrl.sv
// SPI slave configuring NUM_PLL PLL channels.
// Frame: command byte, address byte, then streaming data bytes with an
// auto-incrementing address. SDI is sampled on SCK rise; SDO/sdo_enb change
// on SCK fall. Protocol state is held in reset while CSB is high.
//   SCK, RST        SPI clock, asynchronous active-low reset
//   VGND, VPWR      power pins
//   CSB, SDI        chip select (active-low), serial data in (MSB first)
//   SDO, sdo_enb    serial data out (MSB first), pad enable (active-low)
//   pll_*           per-channel config outputs, all flops
module pll_spi_ctrl
  import pll_spi_pkg::*;
#(
  parameter int unsigned         NUM_PLL  = 2,
  parameter int unsigned         TRIM_W   = 4,
  parameter logic [TRIM_W-1:0]   TRIM_RST = '0,
  parameter logic [11:0]         MFGR_ID  = 12'h456,
  parameter logic [7:0]          PROD_ID  = 8'h11,
  parameter logic [3:0]          MASK_REV = 4'h0
) (
  inout  wire                         VGND,
  inout  wire                         VPWR,
  input  logic                        SCK,
  input  logic                        RST,
  input  logic                        CSB,
  input  logic                        SDI,
  output logic                        SDO,
  output logic                        sdo_enb,
  output logic [NUM_PLL-1:0]          pll_bias_ena,
  output logic [NUM_PLL-1:0]          pll_cp_ena,
  output logic [NUM_PLL-1:0]          pll_vco_ena,
  output logic [NUM_PLL-1:0]          pll_bypass,
  output logic [NUM_PLL*TRIM_W-1:0]   pll_trim
);

  logic unused_pwr;
  assign unused_pwr = VGND ^ VPWR;

  logic       rst_proto_n;
  logic [1:0] state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [6:0] shift_q, shift_d;
  logic [7:0] cmd_q, cmd_d;
  logic [7:0] addr_q, addr_d;
  logic [7:0] tx_q, tx_d;
  logic       sdo_q, sdo_d;
  logic       sdo_enb_q, sdo_enb_d;
  logic       sdo_drive;
  logic [7:0] byte_in;
  logic       byte_done;
  logic       wr_en;
  logic [7:0] rd_addr, rd_data;

  assign rst_proto_n = RST & ~CSB;
  assign byte_in     = {shift_q, SDI};
  assign byte_done   = (bit_cnt_q == 3'd7);

  // The SDO shifter lives in the rise domain: it is loaded on the rise that
  // completes a byte with the register the next byte will stream, so the fall
  // that follows only has to copy bit 7 out. In read-write the old value is
  // therefore captured before the same-rise write lands.
  assign rd_addr = (state_q == ST_ADDRESS) ? byte_in : addr_q + 8'd1;

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q + 3'd1;
    shift_d   = byte_in[6:0];
    cmd_d     = cmd_q;
    addr_d    = addr_q;
    tx_d      = {tx_q[6:0], 1'b0};
    wr_en     = 1'b0;
    case (state_q)
      ST_COMMAND: begin
        if (byte_done) begin
          cmd_d   = byte_in;
          state_d = cmd_valid(byte_in) ? ST_ADDRESS : ST_IGNORE;
        end
      end
      ST_ADDRESS: begin
        if (byte_done) begin
          addr_d  = byte_in;
          state_d = ST_DATA;
          tx_d    = rd_data;
        end
      end
      ST_DATA: begin
        if (byte_done) begin
          wr_en  = cmd_writes(cmd_q);
          addr_d = addr_q + 8'd1;
          tx_d   = rd_data;
        end
      end
      default: bit_cnt_d = bit_cnt_q;
    endcase
  end

  always_ff @(posedge SCK or negedge rst_proto_n) begin
    if (!rst_proto_n) begin
      state_q   <= ST_COMMAND;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      cmd_q     <= '0;
      addr_q    <= '0;
      tx_q      <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      cmd_q     <= cmd_d;
      addr_q    <= addr_d;
      tx_q      <= tx_d;
    end
  end

  always_comb begin
    sdo_drive = (state_q == ST_DATA) && cmd_reads(cmd_q);
    sdo_enb_d = ~sdo_drive;
    sdo_d     = sdo_drive & tx_q[7];
  end

  always_ff @(negedge SCK or negedge rst_proto_n) begin
    if (!rst_proto_n) begin
      sdo_q     <= 1'b0;
      sdo_enb_q <= 1'b1;
    end else begin
      sdo_q     <= sdo_d;
      sdo_enb_q <= sdo_enb_d;
    end
  end

  assign SDO     = sdo_q;
  assign sdo_enb = sdo_enb_q;

  pll_spi_regbank #(
    .NUM_PLL  (NUM_PLL),
    .TRIM_W   (TRIM_W),
    .TRIM_RST (TRIM_RST),
    .MFGR_ID  (MFGR_ID),
    .PROD_ID  (PROD_ID),
    .MASK_REV (MASK_REV)
  ) u_regbank (
    .clk     (SCK),
    .rst_n   (RST),
    .wr_en   (wr_en),
    .wr_addr (addr_q),
    .wr_data (byte_in),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .bias    (pll_bias_ena),
    .cp      (pll_cp_ena),
    .vco     (pll_vco_ena),
    .bypass  (pll_bypass),
    .trim    (pll_trim)
  );

endmodule

// File: tb/tb_pll_spi_ctrl.sv
// Scoreboard bench for pll_spi_ctrl (NUM_PLL=2, TRIM_W=4, TRIM_RST=4'hA).
// Stimulus pushes expected SDO bytes and expected config snapshots; two
// monitors pop and compare when the DUT presents them.
module tb_pll_spi_ctrl;

  localparam int unsigned NP = 2;
  localparam int unsigned TW = 4;

  logic SCK = 1'b0;
  logic RST = 1'b0;
  logic CSB = 1'b1;
  logic SDI = 1'b0;
  logic SDO, sdo_enb;
  logic [NP-1:0]    bias, cp, vco, byp;
  logic [NP*TW-1:0] trim;
  wire VGND, VPWR;
  assign VGND = 1'b0;
  assign VPWR = 1'b1;

  pll_spi_ctrl #(
    .NUM_PLL  (NP),
    .TRIM_W   (TW),
    .TRIM_RST (4'hA)
  ) dut (
    .VGND         (VGND),
    .VPWR         (VPWR),
    .SCK          (SCK),
    .RST          (RST),
    .CSB          (CSB),
    .SDI          (SDI),
    .SDO          (SDO),
    .sdo_enb      (sdo_enb),
    .pll_bias_ena (bias),
    .pll_cp_ena   (cp),
    .pll_vco_ena  (vco),
    .pll_bypass   (byp),
    .pll_trim     (trim)
  );

  always #10 SCK = ~SCK;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [NP-1:0]    bias;
    logic [NP-1:0]    cp;
    logic [NP-1:0]    vco;
    logic [NP-1:0]    byp;
    logic [NP*TW-1:0] trim;
    logic             enb;
  } snap_t;

  typedef struct { string name; logic [7:0] val; } byte_exp_t;
  typedef struct { string name; snap_t v; } cfg_exp_t;

  byte_exp_t sdo_q[$];
  cfg_exp_t  cfg_q[$];
  event      cfg_probe;
  snap_t     m;

  // SDO monitor: the master samples SDO on each rise while the pad is enabled.
  logic [7:0] rx = '0;
  int         rx_cnt = 0;
  always @(posedge SCK) begin
    if (CSB) begin
      rx_cnt = 0;
    end else if (!sdo_enb) begin
      rx = {rx[6:0], SDO};
      rx_cnt++;
      if (rx_cnt == 8) begin
        rx_cnt = 0;
        total++;
        if (sdo_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_sdo_byte: got %02h want none", rx);
        end else begin
          byte_exp_t e;
          e = sdo_q.pop_front();
          if (rx !== e.val) begin
            bad++;
            $display("FAIL %s: got %02h want %02h", e.name, rx, e.val);
          end
        end
      end
    end
  end

  // Config monitor: compares the output snapshot on every probe request.
  initial begin
    forever begin
      @(cfg_probe);
      while (cfg_q.size() > 0) begin
        cfg_exp_t e;
        snap_t    act;
        e = cfg_q.pop_front();
        act.bias = bias;
        act.cp   = cp;
        act.vco  = vco;
        act.byp  = byp;
        act.trim = trim;
        act.enb  = sdo_enb;
        total++;
        if (act !== e.v) begin
          bad++;
          $display("FAIL %s: got bias=%b cp=%b vco=%b byp=%b trim=%h enb=%b want bias=%b cp=%b vco=%b byp=%b trim=%h enb=%b",
                   e.name, act.bias, act.cp, act.vco, act.byp, act.trim, act.enb,
                   e.v.bias, e.v.cp, e.v.vco, e.v.byp, e.v.trim, e.v.enb);
        end
      end
    end
  end

  task automatic probe(input string name, input logic enb);
    snap_t s;
    s     = m;
    s.enb = enb;
    cfg_q.push_back('{name, s});
    -> cfg_probe;
    #1;
  endtask

  task automatic expect_byte(input string name, input logic [7:0] v);
    sdo_q.push_back('{name, v});
  endtask

  task automatic model_reset();
    m      = '0;
    m.byp  = '1;
    m.trim = 8'hAA;
    m.enb  = 1'b1;
  endtask

  task automatic start_frame();
    @(negedge SCK);
    #2 CSB = 1'b0;
  endtask

  task automatic send_bits(input logic [7:0] b, input int n);
    for (int i = 7; i > 7 - n; i--) begin
      SDI = b[i];
      @(posedge SCK);
      @(negedge SCK);
      #2;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_bits(b, 8);
  endtask

  task automatic end_frame();
    CSB = 1'b1;
    SDI = 1'b0;
    #5;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

  initial begin
    model_reset();
    #25;
    probe("reset_state", 1'b1);
    @(negedge SCK);
    #2 RST = 1'b1;

    // Write channel 0 config, then reset mid-frame
    start_frame();
    send_byte(8'h80); send_byte(8'h08); send_byte(8'h0F);
    m.bias[0] = 1'b1; m.cp[0] = 1'b1; m.vco[0] = 1'b1; m.byp[0] = 1'b1;
    probe("wr_ch0_cfg", 1'b1);
    send_bits(8'hFF, 3);
    RST = 1'b0;
    #1;
    model_reset();
    probe("rst_mid_frame", 1'b1);
    end_frame();
    @(negedge SCK);
    #2 RST = 1'b1;

    // Channel 1 config: cp, vco, bypass set, bias clear
    start_frame();
    send_byte(8'h80); send_byte(8'h0C); send_byte(8'h0E);
    m.cp[1] = 1'b1; m.vco[1] = 1'b1; m.byp[1] = 1'b1; m.bias[1] = 1'b0;
    probe("wr_ch1_cfg", 1'b1);
    end_frame();

    // ID read stream
    start_frame();
    send_byte(8'h40);
    probe("rd_enb_after_cmd", 1'b1);
    send_byte(8'h00);
    probe("rd_enb_after_addr", 1'b0);
    expect_byte("id_00", 8'h04); expect_byte("id_01", 8'h56);
    expect_byte("id_02", 8'h11); expect_byte("id_03", 8'h00);
    for (int i = 0; i < 4; i++) send_byte(8'h00);
    end_frame();
    probe("rd_enb_after_csb", 1'b1);

    // Write at FF wraps onto read-only 0x00; dropped trim-hi, reserved, unmapped
    start_frame();
    send_byte(8'h80); send_byte(8'hFF); send_byte(8'h33); send_byte(8'hAA);
    end_frame();
    start_frame();
    send_byte(8'h80); send_byte(8'h0A); send_byte(8'hFF); send_byte(8'hFF);
    end_frame();
    start_frame();
    send_byte(8'h80); send_byte(8'h10); send_byte(8'hFF);
    end_frame();
    probe("ignored_writes", 1'b1);
    start_frame();
    send_byte(8'h40); send_byte(8'hFF);
    expect_byte("rd_ff", 8'h00); expect_byte("rd_wrap_00", 8'h04);
    send_byte(8'h00); send_byte(8'h00);
    end_frame();

    // Read-write: old trim out, new trim in
    start_frame();
    send_byte(8'hC0); send_byte(8'h09);
    expect_byte("rw_old_trim", 8'h0A);
    send_byte(8'hD5);
    m.trim[3:0] = 4'h5;
    probe("rw_trim", 1'b0);
    end_frame();
    start_frame();
    send_byte(8'h40); send_byte(8'h08);
    expect_byte("rd_08", 8'h08); expect_byte("rd_09", 8'h05);
    expect_byte("rd_0a", 8'h00); expect_byte("rd_0b", 8'h00);
    for (int i = 0; i < 4; i++) send_byte(8'h00);
    end_frame();
    start_frame();
    send_byte(8'h40); send_byte(8'h0C);
    expect_byte("rd_0c", 8'h0E); expect_byte("rd_0d", 8'h0A);
    expect_byte("rd_0e", 8'h00); expect_byte("rd_0f", 8'h00);
    expect_byte("rd_10_unmapped", 8'h00);
    for (int i = 0; i < 5; i++) send_byte(8'h00);
    end_frame();

    // Invalid command and partial data byte
    start_frame();
    send_byte(8'h33); send_byte(8'h0C); send_byte(8'h00); send_byte(8'h00);
    probe("ignore_cmd", 1'b1);
    end_frame();
    start_frame();
    send_byte(8'h80); send_byte(8'h0C);
    send_bits(8'h00, 5);
    end_frame();
    probe("partial_byte", 1'b1);
    start_frame();
    send_byte(8'h40); send_byte(8'h0C);
    expect_byte("rd_0c_after_partial", 8'h0E);
    send_byte(8'h00);
    end_frame();

    #50;
    while (sdo_q.size() > 0) begin
      byte_exp_t e;
      e = sdo_q.pop_front();
      total++;
      bad++;
      $display("FAIL %s: got no byte want %02h", e.name, e.val);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
